// File: rtl/bcd_mod_counter_if.sv
// Bus bundle for one BCD clock/calendar field: count strobes, adjust
// buttons, load and runtime-limit inputs, plus the field outputs.
// The master side drives the controls, the slave side is the counter.
interface bcd_mod_counter_if #(
   parameter int DIGITS = 2
);

   logic                  en_tick;
   logic                  run;
   logic                  up;
   logic                  down;
   logic                  ld;
   logic [4*DIGITS-1:0]   ld_val;
   logic                  lim_en;
   logic [4*DIGITS-1:0]   lim_val;
   logic [4*DIGITS-1:0]   count;
   logic                  carry;
   logic                  at_max;

   modport master (
      output en_tick, run, up, down, ld, ld_val, lim_en, lim_val,
      input  count, carry, at_max
   );

   modport slave (
      input  en_tick, run, up, down, ld, ld_val, lim_en, lim_val,
      output count, carry, at_max
   );

endinterface

// File: rtl/bcd_mod_counter.sv
// BCD modulo counter for one clock/calendar field.
// Run mode counts en_tick strobes and pulses carry when the field wraps.
// Adjust mode steps the field up/down from held buttons with auto-repeat.
// The upper limit can be overridden at runtime (e.g. days in the month).
// Valid BCD vectors order exactly like the numbers they encode, so all
// range checks are plain unsigned comparisons on the packed digits.
module bcd_mod_counter #(
   parameter int DIGITS  = 2,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 59,
   parameter int REP_DLY = 8,
   parameter int REP_PER = 2
) (
   input logic              clk,
   input logic              rst,
   bcd_mod_counter_if.slave bus
);

   localparam int W       = 4 * DIGITS;
   localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int CW      = $clog2(REP_MAX + 1);

   // Decimal integer to packed BCD, used for the parameter bounds.
   function automatic logic [W-1:0] to_bcd(input int value);
      logic [W-1:0] r;
      int           v;
      r = '0;
      v = value;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // True when every nibble holds a decimal digit.
   function automatic logic bcd_valid(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Unsigned less-than on packed BCD; kept as a function so a bound
   // of zero does not turn into a constant comparison.
   function automatic logic bcd_lt(input logic [W-1:0] a, input logic [W-1:0] b);
      return a < b;
   endfunction

   // BCD +1, a 9 rolls to 0 and ripples into the next digit.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // BCD -1, a 0 borrows to 9 from the next digit.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (r[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RPT
   } rep_state_t;

   rep_state_t      state;
   logic [CW-1:0]   rep_cnt;
   logic            dir_up;
   logic [W-1:0]    count_q;
   logic            carry_q;

   logic [W-1:0]    emax;
   logic            lim_ok;
   logic            ld_ok;
   logic            clamp;
   logic            at_max_c;
   logic            press;
   logic            same_dir;
   logic            step_req;

   // Effective upper limit: a malformed or out-of-range runtime limit
   // falls back to the static maximum so the field can never get stuck.
   always_comb begin
      lim_ok = bcd_valid(bus.lim_val) &&
               !bcd_lt(bus.lim_val, MIN_BCD) &&
               !bcd_lt(MAX_BCD, bus.lim_val);
      emax   = (bus.lim_en && lim_ok) ? bus.lim_val : MAX_BCD;
   end

   // Load acceptance, limit clamp and the combinational at-max flag.
   always_comb begin
      ld_ok    = bcd_valid(bus.ld_val) &&
                 !bcd_lt(bus.ld_val, MIN_BCD) &&
                 !bcd_lt(emax, bus.ld_val);
      clamp    = bcd_lt(emax, count_q);
      at_max_c = (count_q == emax);
   end

   // Decide whether the held button produces a step in this cycle.
   always_comb begin
      press    = bus.up ^ bus.down;
      same_dir = (dir_up == bus.up);
      step_req = 1'b0;
      if (!bus.run && press) begin
         case (state)
            ST_IDLE: step_req = 1'b1;
            ST_WAIT: step_req = same_dir && (rep_cnt == CW'(REP_DLY));
            ST_RPT:  step_req = same_dir && (rep_cnt == CW'(REP_PER));
            default: step_req = 1'b0;
         endcase
      end
   end

   // Auto-repeat FSM: first step on press, next after REP_DLY, then every REP_PER.
   always_ff @(posedge clk) begin
      if (rst || bus.ld || bus.run) begin
         state   <= ST_IDLE;
         rep_cnt <= '0;
         dir_up  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (press) begin
                  state   <= ST_WAIT;
                  rep_cnt <= CW'(1);
                  dir_up  <= bus.up;
               end
            end
            ST_WAIT: begin
               if (!press || !same_dir) begin
                  state <= ST_IDLE;
               end else if (rep_cnt == CW'(REP_DLY)) begin
                  state   <= ST_RPT;
                  rep_cnt <= CW'(1);
               end else begin
                  rep_cnt <= rep_cnt + CW'(1);
               end
            end
            ST_RPT: begin
               if (!press || !same_dir) begin
                  state <= ST_IDLE;
               end else if (rep_cnt == CW'(REP_PER)) begin
                  rep_cnt <= CW'(1);
               end else begin
                  rep_cnt <= rep_cnt + CW'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               rep_cnt <= '0;
            end
         endcase
      end
   end

   // Count register: reset, then load, then limit clamp, then run/adjust action.
   always_ff @(posedge clk) begin
      carry_q <= 1'b0;
      if (rst) begin
         count_q <= MIN_BCD;
      end else if (bus.ld) begin
         count_q <= ld_ok ? bus.ld_val : MIN_BCD;
      end else if (clamp) begin
         count_q <= emax;
      end else if (bus.run) begin
         if (bus.en_tick) begin
            if (at_max_c) begin
               count_q <= MIN_BCD;
               carry_q <= 1'b1;
            end else begin
               count_q <= bcd_inc(count_q);
            end
         end
      end else if (step_req) begin
         if (bus.up) begin
            count_q <= at_max_c ? MIN_BCD : bcd_inc(count_q);
         end else begin
            count_q <= (count_q == MIN_BCD) ? emax : bcd_dec(count_q);
         end
      end
   end

   assign bus.count  = count_q;
   assign bus.carry  = carry_q;
   assign bus.at_max = at_max_c;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: two fields (0..59 and 1..31) share one
// stimulus stream and are each compared every cycle with an arithmetic
// model that works on plain integers and hold durations.
module tb_bcd_mod_counter;

   localparam int REP_DLY = 8;
   localparam int REP_PER = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_tick;
   logic       run;
   logic       up;
   logic       down;
   logic       ld;
   logic [7:0] ld_val;
   logic       lim_en;
   logic [7:0] lim_val;

   int checks = 0;
   int errors = 0;

   int minv[2];
   int maxv[2];
   int m_cnt[2];
   bit m_carry[2];
   bit m_idle[2];
   int m_dir[2];
   int m_hold[2];

   bcd_mod_counter_if #(.DIGITS(2)) bus_a ();
   bcd_mod_counter_if #(.DIGITS(2)) bus_b ();

   assign bus_a.en_tick = en_tick;
   assign bus_a.run     = run;
   assign bus_a.up      = up;
   assign bus_a.down    = down;
   assign bus_a.ld      = ld;
   assign bus_a.ld_val  = ld_val;
   assign bus_a.lim_en  = lim_en;
   assign bus_a.lim_val = lim_val;
   assign bus_b.en_tick = en_tick;
   assign bus_b.run     = run;
   assign bus_b.up      = up;
   assign bus_b.down    = down;
   assign bus_b.ld      = ld;
   assign bus_b.ld_val  = ld_val;
   assign bus_b.lim_en  = lim_en;
   assign bus_b.lim_val = lim_val;

   bcd_mod_counter #(
      .DIGITS(2), .MIN_VAL(0), .MAX_VAL(59), .REP_DLY(REP_DLY), .REP_PER(REP_PER)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   bcd_mod_counter #(
      .DIGITS(2), .MIN_VAL(1), .MAX_VAL(31), .REP_DLY(REP_DLY), .REP_PER(REP_PER)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic bit bcd_ok(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic int bcd_int(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic int emax_of(input int k);
      int lv;
      lv = bcd_int(lim_val);
      if (lim_en && bcd_ok(lim_val) && lv >= minv[k] && lv <= maxv[k]) return lv;
      return maxv[k];
   endfunction

   // One clock of field k from the current inputs, in decimal integers.
   task automatic model_cycle(input int k);
      int e;
      int lv;
      int d;
      bit press;
      bit do_step;
      e       = emax_of(k);
      press   = up ^ down;
      d       = up ? 1 : -1;
      do_step = 1'b0;
      m_carry[k] = 1'b0;
      if (rst) begin
         m_cnt[k]  = minv[k];
         m_idle[k] = 1'b1;
      end else if (ld) begin
         lv = bcd_int(ld_val);
         m_cnt[k]  = (bcd_ok(ld_val) && lv >= minv[k] && lv <= e) ? lv : minv[k];
         m_idle[k] = 1'b1;
      end else begin
         if (run) begin
            m_idle[k] = 1'b1;
         end else if (m_idle[k]) begin
            if (press) begin
               do_step   = 1'b1;
               m_idle[k] = 1'b0;
               m_dir[k]  = d;
               m_hold[k] = 0;
            end
         end else if (press && d == m_dir[k]) begin
            m_hold[k]++;
            if (m_hold[k] == REP_DLY ||
                (m_hold[k] > REP_DLY && (m_hold[k] - REP_DLY) % REP_PER == 0))
               do_step = 1'b1;
         end else begin
            m_idle[k] = 1'b1;
         end
         if (m_cnt[k] > e) begin
            m_cnt[k] = e;
         end else if (run) begin
            if (en_tick) begin
               if (m_cnt[k] == e) begin
                  m_cnt[k]   = minv[k];
                  m_carry[k] = 1'b1;
               end else begin
                  m_cnt[k] = m_cnt[k] + 1;
               end
            end
         end else if (do_step) begin
            if (d > 0) m_cnt[k] = (m_cnt[k] == e) ? minv[k] : m_cnt[k] + 1;
            else       m_cnt[k] = (m_cnt[k] == minv[k]) ? e : m_cnt[k] - 1;
         end
      end
   endtask

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Compare both fields against the model.
   task automatic check_models();
      check_output("a count", bus_a.count, to_bcd(m_cnt[0]));
      check_bit("a carry", bus_a.carry, m_carry[0]);
      check_bit("a at_max", bus_a.at_max, m_cnt[0] == emax_of(0));
      check_output("b count", bus_b.count, to_bcd(m_cnt[1]));
      check_bit("b carry", bus_b.carry, m_carry[1]);
      check_bit("b at_max", bus_b.at_max, m_cnt[1] == emax_of(1));
   endtask

   // Advance one clock with the inputs currently driven, then check.
   task automatic apply_stimulus();
      model_cycle(0);
      model_cycle(1);
      @(posedge clk);
      #1;
      check_models();
   endtask

   task automatic load_value(input logic [7:0] v);
      ld     = 1'b1;
      ld_val = v;
      apply_stimulus();
      ld     = 1'b0;
   endtask

   // Directed scenarios first, then a randomized run.
   initial begin
      minv = '{0, 1};
      maxv = '{59, 31};
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_carry[k] = 0; m_idle[k] = 1; m_dir[k] = 0; m_hold[k] = 0;
      end
      rst = 1'b1; en_tick = 1'b0; run = 1'b1; up = 1'b0; down = 1'b0;
      ld = 1'b0; ld_val = 8'h00; lim_en = 1'b0; lim_val = 8'h00;
      @(negedge clk);
      apply_stimulus();
      apply_stimulus();
      rst = 1'b0;
      check_output("reset count a", bus_a.count, 8'h00);
      check_output("reset count b", bus_b.count, 8'h01);

      $display("[TB] run-mode wrap");
      load_value(8'h58);
      check_output("T2 load", bus_a.count, 8'h58);
      en_tick = 1'b1;
      apply_stimulus();
      check_output("T2 tick1", bus_a.count, 8'h59);
      check_bit("T2 at_max", bus_a.at_max, 1'b1);
      apply_stimulus();
      check_output("T2 wrap", bus_a.count, 8'h00);
      check_bit("T2 carry", bus_a.carry, 1'b1);
      en_tick = 1'b0;
      apply_stimulus();
      check_bit("T2 carry drop", bus_a.carry, 1'b0);

      $display("[TB] reset mid-count");
      en_tick = 1'b1;
      apply_stimulus();
      apply_stimulus();
      rst = 1'b1;
      apply_stimulus();
      apply_stimulus();
      check_output("T1 count", bus_a.count, 8'h00);
      check_bit("T1 carry", bus_a.carry, 1'b0);
      check_bit("T1 at_max", bus_a.at_max, 1'b0);
      rst = 1'b0; en_tick = 1'b0;

      $display("[TB] adjust single steps");
      run = 1'b0;
      load_value(8'h00);
      down = 1'b1;
      apply_stimulus();
      check_output("T3 down wrap", bus_a.count, 8'h59);
      down = 1'b0;
      apply_stimulus();
      up = 1'b1;
      apply_stimulus();
      check_output("T3 up wrap", bus_a.count, 8'h00);
      check_bit("T3 carry", bus_a.carry, 1'b0);
      down = 1'b1;
      apply_stimulus();
      apply_stimulus();
      check_output("T3 both", bus_a.count, 8'h00);
      up = 1'b0; down = 1'b0;
      apply_stimulus();

      $display("[TB] auto-repeat");
      load_value(8'h10);
      up = 1'b1;
      for (int c = 0; c < 14; c++) apply_stimulus();
      check_output("T4 repeat", bus_a.count, 8'h14);
      up = 1'b0;
      apply_stimulus();

      $display("[TB] runtime limit");
      load_value(8'h30);
      check_output("T5 load b", bus_b.count, 8'h30);
      lim_en = 1'b1; lim_val = 8'h28;
      apply_stimulus();
      check_output("T5 clamp b", bus_b.count, 8'h28);
      run = 1'b1; en_tick = 1'b1;
      apply_stimulus();
      check_output("T5 wrap b", bus_b.count, 8'h01);
      check_bit("T5 carry b", bus_b.carry, 1'b1);
      en_tick = 1'b0; lim_en = 1'b0;

      $display("[TB] load rules");
      load_value(8'h7A);
      check_output("T6 bad load a", bus_a.count, 8'h00);
      check_output("T6 bad load b", bus_b.count, 8'h01);
      load_value(8'h59);
      en_tick = 1'b1;
      load_value(8'h25);
      check_output("T6 ld wins", bus_a.count, 8'h25);
      check_bit("T6 no carry", bus_a.carry, 1'b0);
      en_tick = 1'b0;

      $display("[TB] randomized run");
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         ld  = ($urandom_range(0, 23) == 0);
         ld_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : to_bcd($urandom_range(0, 70));
         if ($urandom_range(0, 39) == 0) run = ~run;
         if ($urandom_range(0, 9) == 0) begin
            up   = 1'($urandom_range(0, 1));
            down = 1'($urandom_range(0, 1));
         end
         en_tick = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) begin
            lim_en  = 1'($urandom_range(0, 1));
            lim_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : to_bcd($urandom_range(0, 65));
         end
         apply_stimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
